// File: rtl/simple_proc_pkg.sv
// simple_proc shared definitions: opcodes, control states
// and data-bus source selection.
package simple_proc_pkg;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVT = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      BUS_ZERO = 3'd0,
      BUS_OPND = 3'd1,
      BUS_MVT  = 3'd2,
      BUS_RX   = 3'd3,
      BUS_G    = 3'd4
   } bus_sel_t;

endpackage

// File: rtl/simple_proc_regn.sv
// regn: 16-bit register with load enable, async active-low clear.
// Ports: clk, rst_n, en (load), d (data in), q (stored value).
module regn (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] d,
   output logic [15:0] q
);

   logic [15:0] q_d;
   logic [15:0] q_q;

   always_comb begin
      q_d = q_q;
      if (en) q_d = d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= 16'h0000;
      else        q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/simple_proc.sv
// simple_proc: multicycle 16-bit CPU (mv, mvt, add, sub), 8 regs.
// Ports: Clock, Resetn, DIN, Run in; Done, BusWires out; Rsel/Rout debug read.
module simple_proc
   import simple_proc_pkg::*;
(
   input  logic        Clock,
   input  logic        Resetn,
   input  logic [15:0] DIN,
   input  logic        Run,
   output logic        Done,
   output logic [15:0] BusWires,
   input  logic [2:0]  Rsel,
   output logic [15:0] Rout
);

   state_t      state_q;
   state_t      state_d;
   bus_sel_t    bus_sel;

   logic [15:0] ir_q;
   logic [15:0] a_q;
   logic [15:0] g_q;
   logic [15:0] g_d;
   logic [15:0] r_q [8];

   logic        ir_en;
   logic        a_en;
   logic        g_en;
   logic        rx_wr;

   logic [2:0]  op;
   logic        imm;
   logic [2:0]  rx;
   logic [2:0]  ry;
   logic [8:0]  dfld;
   logic [15:0] operand;
   logic [15:0] rx_val;

   assign op   = ir_q[15:13];
   assign imm  = ir_q[12];
   assign rx   = ir_q[11:9];
   assign dfld = ir_q[8:0];
   assign ry   = dfld[2:0];

   assign operand = imm ? {7'b0, dfld} : r_q[ry];
   assign rx_val  = r_q[rx];

   // rX is untouched until T3, so a same-register operand
   // still sees the pre-instruction value in T2.
   assign g_d = (op == OP_SUB) ? a_q - operand : a_q + operand;

   always_comb begin
      state_d = state_q;
      bus_sel = BUS_ZERO;
      ir_en   = 1'b0;
      a_en    = 1'b0;
      g_en    = 1'b0;
      rx_wr   = 1'b0;
      Done    = 1'b0;
      case (state_q)
         T0: begin
            if (Run) begin
               ir_en   = 1'b1;
               state_d = T1;
            end
         end
         T1: begin
            state_d = T0;
            case (op)
               OP_MV: begin
                  bus_sel = BUS_OPND;
                  rx_wr   = 1'b1;
                  Done    = 1'b1;
               end
               OP_MVT: begin
                  bus_sel = BUS_MVT;
                  rx_wr   = 1'b1;
                  Done    = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  bus_sel = BUS_RX;
                  a_en    = 1'b1;
                  state_d = T2;
               end
               default: Done = 1'b1;
            endcase
         end
         T2: begin
            g_en    = 1'b1;
            state_d = T3;
         end
         T3: begin
            bus_sel = BUS_G;
            rx_wr   = 1'b1;
            Done    = 1'b1;
            state_d = T0;
         end
         default: state_d = T0;
      endcase
   end

   always_comb begin
      BusWires = 16'h0000;
      case (bus_sel)
         BUS_OPND: BusWires = operand;
         BUS_MVT:  BusWires = {dfld[7:0], 8'h00};
         BUS_RX:   BusWires = rx_val;
         BUS_G:    BusWires = g_q;
         default:  BusWires = 16'h0000;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state_q <= T0;
      else         state_q <= state_d;
   end

   regn u_ir (
      .clk(Clock), .rst_n(Resetn), .en(ir_en), .d(DIN), .q(ir_q)
   );

   regn u_a (
      .clk(Clock), .rst_n(Resetn), .en(a_en), .d(BusWires), .q(a_q)
   );

   regn u_g (
      .clk(Clock), .rst_n(Resetn), .en(g_en), .d(g_d), .q(g_q)
   );

   for (genvar i = 0; i < 8; i++) begin : g_regs
      regn u_r (
         .clk  (Clock),
         .rst_n(Resetn),
         .en   (rx_wr && (rx == 3'(i))),
         .d    (BusWires),
         .q    (r_q[i])
      );
   end

   assign Rout = r_q[Rsel];

endmodule

// File: doc/simple_proc.md
# simple_proc

Multicycle 16-bit processor that consumes the instruction word `DIN` delivered by the instruction memory. The memory address counter steps independently of this block. The processor holds eight general-purpose registers and executes `mv`, `mvt`, `add` and `sub`. `Run` starts a fetch and `Done` marks instruction completion. It sits directly downstream of the instruction memory in the lab top level, which shows `Done` and `Run` on LEDs.

## Interface
- No parameters; data width fixed at 16, register count fixed at 8.
- `Clock`  in  1  processor clock; all state changes on rising edge
- `Resetn`  in  1  asynchronous, active-low reset
- `DIN`  in  16  instruction word from instruction memory
- `Run`  in  1  start request, sampled only in state T0
- `Done`  out  1  high during the final cycle of every instruction
- `BusWires`  out  16  internal data bus (visible for debug and bench)
- `Rsel`  in  3  debug register select
- `Rout`  out  16  contents of register `Rsel`, combinational read

## Operation
- Instruction format is `DIN[15:13]` opcode III, then `DIN[12]` mode M, then `DIN[11:9]` rX, then `DIN[8:0]` D.
- Operand selection:
  - M=0: operand is register rY = D[2:0].
  - M=1: operand is the immediate D zero-extended to 16 bits.
- Opcodes:
  - 000 `mv`: rX ← operand.
  - 001 `mvt`: rX ← {D[7:0], 8'h00}; M is ignored.
  - 010 `add`: rX ← rX + operand.
  - 011 `sub`: rX ← rX − operand.
  - 100–111: no-op; no register write, `Done` asserted in T1.
- Arithmetic is modulo 2^16. There are no flags and carry is discarded.
- FSM states:
  - T0 idle/fetch: if `Run`=1, IR ← DIN and go to T1; otherwise stay in T0.
  - T1:
    - `mv`/`mvt`/no-op: perform the write (if any), `Done`=1, go to T0.
    - `add`/`sub`: A ← rX, go to T2.
  - T2: G ← A ± operand, go to T3.
  - T3: rX ← G, `Done`=1, go to T0.
- `BusWires` per state:
  - T1: the selected source (operand, mvt value, or rX).
  - T3: G.
  - Otherwise: 16'h0000.
- Source equal to destination (e.g. `add r2, r2`) reads the pre-instruction value.
- Reset values: all registers r0–r7, IR, A and G are 0; state is T0; `Done`=0; `BusWires`=0.

## Timing
- IR is captured on the rising edge that ends T0 when `Run`=1. DIN must be stable during T0.
- Latency from the capture edge:
  - `mv`/`mvt`/no-op: `Done` in the next cycle; register updated on the edge ending that cycle. Total 2 cycles per instruction.
  - `add`/`sub`: `Done` in the third cycle after capture; 4 cycles per instruction.
- `Done` is a decode of state and IR, with no extra register stage.
- `Run` is ignored outside T0. Dropping `Run` mid-instruction lets the instruction complete.
- Back-to-back execution: with `Run` held high, T0 directly follows a `Done` cycle, so the next fetch occurs one cycle after `Done`.
- Asserting `Resetn` low at any state immediately forces T0 and clears all state. No partial write survives.
- `Rout` reflects a register write on the edge that performs it.

## Structure
- Shared package holds:
  - opcode constants `OP_MV`, `OP_MVT`, `OP_ADD`, `OP_SUB`;
  - state encoding T0–T3;
  - bus-select encoding.
- Sub-module `regn` is a 16-bit register with enable and async active-low clear. It is instantiated for r0–r7, IR, A and G.
- Control FSM, bus multiplexer and add/sub unit stay in `simple_proc`.

## Test plan
- Reset: `Resetn`=0 mid-T2 of an `add` → state T0, `Done`=0, `Rout`=0 for all `Rsel`.
- Immediate load: `Run`=1 with DIN=16'h1005 (`mv r0,#5`) → `Done` high one cycle after capture, r0=16'h0005.
- mvt: DIN=16'h32A5 (`mvt r1,#A5`) → r1=16'hA500.
- Register add: r0=5, r1=16'hA500, DIN=16'h4200 (`add r1,r0`, M=0) → `Done` in the third cycle after capture, r1=16'hA505.
- Wrap-around:
  - r2=0, DIN=16'h7401 (`sub r2,#1`) → r2=16'hFFFF.
  - Then DIN=16'h5401 (`add r2,#1`) → r2=16'h0000.
- Run gating: `Run`=0 for 5 cycles → remains in T0, no IR change. `Run` deasserted during T2 → the `add` still completes and `Done` pulses once.
